// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle CPU: instruction field positions,
// opcode and FSM state encodings.
package mcpu_pkg;
  localparam int INSTR_W = 16;

  // Instruction field LSB positions (op is 4 bits, register fields 3 bits)
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 9;
  localparam int RA_LSB = 6;
  localparam int RB_LSB = 3;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_ADD  = 4'd1,  OP_SUB  = 4'd2,  OP_AND  = 4'd3,
    OP_OR   = 4'd4,  OP_XOR  = 4'd5,  OP_ADDI = 4'd6,  OP_LD   = 4'd7,
    OP_ST   = 4'd8,  OP_BZ   = 4'd9,  OP_BN   = 4'd10, OP_BC   = 4'd11,
    OP_JMP  = 4'd12, OP_LDI  = 4'd13, OP_RSVD = 4'd14, OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_e;
endpackage

// File: rtl/mcpu_regfile.sv
// 8 x DATA_W register file.
// Ports: three asynchronous read ports (a, b, d), one write port sampled on
// the rising edge of clk, asynchronous active-low clear of all registers.
module mcpu_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [2:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [2:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [2:0]        raddr_d,
  output logic [DATA_W-1:0] rdata_d,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [7:0][DATA_W-1:0] regs;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)  regs <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_d = regs[raddr_d];
endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit-instruction CPU: FETCH/DECODE/EXECUTE/MEM/WB/HALT FSM
// with req/ready handshakes to external instruction and data memories.
// Ports: clk, reset_CPU (async active-low); imem_* fetch handshake;
// dmem_* load/store handshake; halted and registered Z/C/N flags;
// dbg_pc, dbg_state and a one-cycle register-write retire pulse dbg_wb_*.
module multicycle_cpu
  import mcpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               reset_CPU,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ready,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               halted,
  output logic               zero_flag,
  output logic               carrier_flag,
  output logic               negative_flag,
  output logic [PC_W-1:0]    dbg_pc,
  output logic [2:0]         dbg_state,
  output logic               dbg_wb_valid,
  output logic [2:0]         dbg_wb_addr,
  output logic [DATA_W-1:0]  dbg_wb_data
);
  state_e               state, state_nx;
  logic [PC_W-1:0]      pc;
  logic [INSTR_W-1:0]   ir;
  logic [DATA_W-1:0]    op_a, op_b, op_d, res;
  logic [ADDR_W-1:0]    maddr;
  logic                 zf, cf, nf;

  opcode_e              op;
  logic [2:0]           rd, ra, rb;
  logic [DATA_W-1:0]    rf_a, rf_b, rf_d;
  logic [DATA_W-1:0]    sext6, alu_res, addr_sum;
  logic [DATA_W:0]      add_full;
  logic                 alu_c, alu_op, taken;

  assign op = opcode_e'(ir[OP_LSB +: 4]);
  assign rd = ir[RD_LSB +: 3];
  assign ra = ir[RA_LSB +: 3];
  assign rb = ir[RB_LSB +: 3];

  mcpu_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk     (clk),
    .clr_n   (reset_CPU),
    .raddr_a (ra),
    .rdata_a (rf_a),
    .raddr_b (rb),
    .rdata_b (rf_b),
    .raddr_d (rd),
    .rdata_d (rf_d),
    .we      (state == S_WB),
    .waddr   (rd),
    .wdata   (res)
  );

  // Size casts of a signed operand sign-extend (or truncate) to the target width
  assign sext6    = DATA_W'($signed(ir[5:0]));
  assign addr_sum = op_a + sext6;
  assign add_full = {1'b0, op_a} + {1'b0, (op == OP_ADDI) ? sext6 : op_b};

  // ALU; alu_op marks the opcodes that are allowed to update the flags
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_op  = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin {alu_c, alu_res} = add_full; alu_op = 1'b1; end
      OP_SUB: begin
        alu_res = op_a - op_b;
        alu_c   = (op_a >= op_b);  // no-borrow convention
        alu_op  = 1'b1;
      end
      OP_AND:  begin alu_res = op_a & op_b; alu_op = 1'b1; end
      OP_OR:   begin alu_res = op_a | op_b; alu_op = 1'b1; end
      OP_XOR:  begin alu_res = op_a ^ op_b; alu_op = 1'b1; end
      OP_LDI:  alu_res = DATA_W'(ir[8:0]);
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_BZ:   taken = zf;
      OP_BN:   taken = nf;
      OP_BC:   taken = cf;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_CPU) begin
    if (!reset_CPU) state <= S_FETCH;
    else            state <= state_nx;
  end

  // Next state and handshake outputs. imem_req is gated by reset so the
  // fetch request stays low while the core is held in reset.
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = reset_CPU;
        if (imem_ready) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = (op == OP_HALT) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LDI: state_nx = S_WB;
          OP_LD, OP_ST: state_nx = S_MEM;
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) state_nx = (op == OP_LD) ? S_WB : S_FETCH;
      end
      S_WB:    state_nx = S_FETCH;
      S_HALT:  halted   = 1'b1;
      default: state_nx = S_FETCH;
    endcase
  end

  // Datapath registers; pc already holds the next-instruction address when
  // a branch executes, so it is the branch base.
  always_ff @(posedge clk or negedge reset_CPU) begin
    if (!reset_CPU) begin
      pc    <= '0;
      ir    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_d  <= '0;
      res   <= '0;
      maddr <= '0;
      zf    <= 1'b0;
      cf    <= 1'b0;
      nf    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (imem_ready) begin
          ir <= imem_rdata;
          pc <= pc + PC_W'(1);
        end
        S_DECODE: begin
          op_a <= rf_a;
          op_b <= rf_b;
          op_d <= rf_d;
        end
        S_EXECUTE: begin
          res   <= alu_res;
          maddr <= ADDR_W'(addr_sum);
          if (alu_op) begin
            zf <= (alu_res == '0);
            nf <= alu_res[DATA_W-1];
            cf <= alu_c;
          end
          if (op == OP_JMP) pc <= PC_W'(ir[11:0]);
          else if (taken)   pc <= pc + PC_W'($signed(ir[8:0]));
        end
        S_MEM: if (dmem_ready && op == OP_LD) res <= dmem_rdata;
        default: ;
      endcase
    end
  end

  assign imem_addr     = pc;
  assign dmem_we       = (op == OP_ST);
  assign dmem_addr     = maddr;
  assign dmem_wdata    = op_d;
  assign zero_flag     = zf;
  assign carrier_flag  = cf;
  assign negative_flag = nf;
  assign dbg_pc        = pc;
  assign dbg_state     = state;
  assign dbg_wb_valid  = (state == S_WB);
  assign dbg_wb_addr   = rd;
  assign dbg_wb_data   = res;
endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu (DATA_W=8, PC_W=8, ADDR_W=6): zero-wait
// instruction memory, data memory with a programmable number of wait cycles.
module tb_multicycle_cpu;
  logic        clk = 1'b0;
  logic        reset_CPU = 1'b0;
  logic        imem_req, imem_ready;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [5:0]  dmem_addr;
  logic [7:0]  dmem_wdata, dmem_rdata;
  logic        halted, zero_flag, carrier_flag, negative_flag;
  logic [7:0]  dbg_pc;
  logic [2:0]  dbg_state;
  logic        dbg_wb_valid;
  logic [2:0]  dbg_wb_addr;
  logic [7:0]  dbg_wb_data;

  multicycle_cpu #(.DATA_W(8), .PC_W(8), .ADDR_W(6)) dut (
    .clk(clk), .reset_CPU(reset_CPU),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .halted(halted), .zero_flag(zero_flag), .carrier_flag(carrier_flag), .negative_flag(negative_flag),
    .dbg_pc(dbg_pc), .dbg_state(dbg_state), .dbg_wb_valid(dbg_wb_valid),
    .dbg_wb_addr(dbg_wb_addr), .dbg_wb_data(dbg_wb_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models
  logic [15:0] imem [256];
  logic [7:0]  dmem [64];
  int          dwait = 0;
  int          dcnt  = 0;
  assign imem_ready = imem_req;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ready = dmem_req && (dcnt >= dwait);
  assign dmem_rdata = dmem[dmem_addr];
  always @(posedge clk) begin
    if (!dmem_req || dmem_ready) dcnt <= 0;
    else                         dcnt <= dcnt + 1;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  int nvec = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // State captured between two consecutive fetches
  logic [7:0] f_addr;
  int         f_cyc = 0, prev_cyc = 0;
  logic       wb_seen, dm_seen, dm_unstable;
  logic [2:0] wb_a;
  logic [7:0] wb_d, dm_d;
  logic [5:0] dm_a;

  task automatic next_fetch();
    wb_seen = 0; dm_seen = 0; dm_unstable = 0;
    prev_cyc = f_cyc;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (dbg_wb_valid) begin wb_seen = 1; wb_a = dbg_wb_addr; wb_d = dbg_wb_data; end
      if (dmem_req) begin
        if (!dm_seen) begin dm_seen = 1; dm_a = dmem_addr; dm_d = dmem_wdata; end
        else if (dmem_addr !== dm_a || dmem_wdata !== dm_d) dm_unstable = 1;
      end
      if (imem_req && imem_ready) begin f_addr = imem_addr; f_cyc = cyc; return; end
    end
    nvec++; nfail++;
    $error("FAIL fetch_timeout: observed no fetch in 64 cycles, expected a fetch");
    f_addr = 'x;
  endtask

  // Advance to the next fetch; check its address and (if exp_cyc>0) the
  // cycle count of the instruction that just completed.
  task automatic step(input logic [7:0] exp_addr, input int exp_cyc, input string tag);
    next_fetch();
    chk({tag, "_addr"}, f_addr, exp_addr);
    if (exp_cyc > 0) chk({tag, "_cycles"}, f_cyc - prev_cyc, exp_cyc);
  endtask

  task automatic wbchk(input logic [2:0] a, input logic [7:0] d, input string tag);
    chk({tag, "_wb_valid"}, wb_seen, 1);
    chk({tag, "_wb_addr"}, wb_a, a);
    chk({tag, "_wb_data"}, wb_d, d);
  endtask

  task automatic flags(input logic z, input logic c, input logic n, input string tag);
    chk({tag, "_zcn"}, {zero_flag, carrier_flag, negative_flag}, {z, c, n});
  endtask

  initial begin
    int req_cnt;
    logic hit;
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    for (int i = 0; i < 64; i++)  dmem[i] = 8'h00;
    imem[0]   = 16'hD205; // LDI r1,5
    imem[1]   = 16'hD405; // LDI r2,5
    imem[2]   = 16'h2650; // SUB r3,r1,r2
    imem[3]   = 16'h9002; // BZ +2
    imem[4]   = 16'hC008; // JMP 8
    imem[6]   = 16'h6A41; // ADDI r5,r1,1
    imem[7]   = 16'hC003; // JMP 3
    imem[8]   = 16'h8203; // ST r1,[r0+3]
    imem[9]   = 16'h7803; // LD r4,[r0+3]
    imem[10]  = 16'hD2FF; // LDI r1,255
    imem[11]  = 16'h6241; // ADDI r1,r1,1
    imem[12]  = 16'h2C50; // SUB r6,r1,r2
    imem[13]  = 16'hB1FF; // BC -1
    imem[14]  = 16'hC1FE; // JMP 0x1FE -> 254
    imem[254] = 16'h1FB0; // ADD r7,r6,r6
    imem[255] = 16'hA011; // BN +17 (base wraps to 0)
    imem[17]  = 16'h55F0; // XOR r2,r7,r6
    imem[18]  = 16'h47F0; // OR r3,r7,r6
    imem[19]  = 16'h0000; // NOP
    imem[20]  = 16'hE000; // reserved
    imem[21]  = 16'hF000; // HALT

    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wb_valid", dbg_wb_valid, 0);
    chk("rst_pc", dbg_pc, 0);
    chk("rst_state", dbg_state, 0);
    flags(0, 0, 0, "rst");

    @(posedge clk); #1 reset_CPU = 1'b1;
    step(8'd0,   0, "fetch0");
    step(8'd1,   4, "ldi_r1");   wbchk(3'd1, 8'd5, "ldi_r1");
    step(8'd2,   4, "ldi_r2");   wbchk(3'd2, 8'd5, "ldi_r2");
    step(8'd3,   4, "sub");      wbchk(3'd3, 8'd0, "sub"); flags(1, 1, 0, "sub");
    step(8'd6,   3, "bz_taken");
    step(8'd7,   4, "addi");     wbchk(3'd5, 8'd6, "addi"); flags(0, 0, 0, "addi");
    step(8'd3,   3, "jmp3");
    step(8'd4,   3, "bz_not_taken");
    step(8'd8,   3, "jmp8");
    dwait = 3;
    step(8'd9,   7, "st_wait");
    chk("st_req_seen", dm_seen, 1);
    chk("st_addr", dm_a, 6'd3);
    chk("st_wdata", dm_d, 8'd5);
    chk("st_stable", dm_unstable, 0);
    step(8'd10,  8, "ld_wait");  wbchk(3'd4, 8'd5, "ld");
    chk("ld_stable", dm_unstable, 0);
    dwait = 0;
    step(8'd11,  4, "ldi255");   wbchk(3'd1, 8'hFF, "ldi255");
    step(8'd12,  4, "addi_wrap"); wbchk(3'd1, 8'h00, "addi_wrap"); flags(1, 1, 0, "addi_wrap");
    step(8'd13,  4, "sub_neg");  wbchk(3'd6, 8'hFB, "sub_neg"); flags(0, 0, 1, "sub_neg");
    step(8'd14,  3, "bc_not_taken");
    step(8'd254, 3, "jmp_trunc");
    step(8'd255, 4, "add_carry"); wbchk(3'd7, 8'hF6, "add_carry"); flags(0, 1, 1, "add_carry");
    step(8'd17,  3, "bn_wrap");
    step(8'd18,  4, "xor");      wbchk(3'd2, 8'h0D, "xor"); flags(0, 0, 0, "xor");
    step(8'd19,  4, "or");       wbchk(3'd3, 8'hFF, "or");  flags(0, 0, 1, "or");
    step(8'd20,  3, "nop");      chk("nop_no_wb", wb_seen, 0);
    step(8'd21,  3, "rsvd");

    req_cnt = 0;
    repeat (22) begin
      @(negedge clk);
      if (imem_req) req_cnt++;
    end
    chk("halt_flag", halted, 1);
    chk("halt_state", dbg_state, 3'd5);
    chk("halt_no_fetch", req_cnt, 0);

    // Reset out of HALT, then stall a store and reset mid-access
    imem[0] = 16'h8203;
    dwait   = 1000;
    #1 reset_CPU = 1'b0;
    #1;
    chk("rst2_imem_req", imem_req, 0);
    chk("rst2_halted", halted, 0);
    chk("rst2_pc", dbg_pc, 0);
    @(posedge clk); #1 reset_CPU = 1'b1;
    step(8'd0, 0, "rst2_fetch0");
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = dmem_req;
    end
    chk("stall_req_seen", hit, 1);
    repeat (2) @(negedge clk);
    chk("stall_req_held", dmem_req, 1);
    #1 reset_CPU = 1'b0;
    #1;
    chk("midreset_dmem_req", dmem_req, 0);
    chk("midreset_pc", dbg_pc, 0);
    chk("midreset_state", dbg_state, 0);
    imem[0] = 16'hD205;
    dwait   = 0;
    @(posedge clk); #1 reset_CPU = 1'b1;
    step(8'd0, 0, "rst3_fetch0");
    step(8'd1, 4, "rst3_ldi");   wbchk(3'd1, 8'd5, "rst3_ldi");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle CPU top. It runs a 16-bit-instruction, 8-register ISA through a FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine. Instruction and data memories are external and reached through req/ready handshakes, so wait-state memories work unchanged. Data, PC and data-address widths are parameters; the core adds registered flags, conditional branches, HALT and retire-debug outputs that the single-cycle top lacks.

## Interface
- DATA_W, 8: register/ALU/data width, ≥4
- PC_W, 8: instruction address width, ≤12
- ADDR_W, 6: data address width, ≤DATA_W
- clk  in  1  clock; all state on rising edge
- reset_CPU  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  ADDR_W  data address
- dmem_wdata  out  DATA_W  store data
- dmem_ready  in  1  access complete; dmem_rdata valid on load
- dmem_rdata  in  DATA_W  load data
- halted  out  1  core stopped in HALT
- zero_flag, carrier_flag, negative_flag  out  1 each  registered flags
- dbg_pc  out  PC_W  current pc
- dbg_state  out  3  FSM state encoding
- dbg_wb_valid  out  1  one-cycle pulse on register write
- dbg_wb_addr  out  3  written register
- dbg_wb_data  out  DATA_W  written value

## Operation

**Instruction fields:** op[15:12], rd[11:9], ra[8:6], rb[5:3], imm6[5:0], imm9[8:0], imm12[11:0].

**Opcodes:**
- 0 NOP
- 1 ADD rd=ra+rb
- 2 SUB rd=ra−rb
- 3 AND
- 4 OR
- 5 XOR
- 6 ADDI rd=ra+sext(imm6)
- 7 LD rd=mem[ra+sext(imm6)]
- 8 ST mem[ra+sext(imm6)]=rd
- 9 BZ, 10 BN, 11 BC: if flag set, pc=pc+sext(imm9)
- 12 JMP pc=imm12[PC_W-1:0]
- 13 LDI rd=imm9 (zero-extended, truncated to DATA_W)
- 14 reserved, executes as NOP
- 15 HALT

**Arithmetic and flags:**
- All arithmetic is modulo 2^DATA_W.
- The data address is the low ADDR_W bits of the sum.
- pc wraps modulo 2^PC_W.
- Flags update only on opcodes 1–6; every other opcode preserves them.
  - Z: result==0.
  - N: result MSB.
  - C for ADD/ADDI: carry out. C for SUB: 1 when ra≥rb unsigned (no borrow). C for logic ops: cleared.

**FSM:**
- FETCH
  - imem_req=1, imem_addr=pc.
  - When imem_ready=1: latch IR, pc←pc+1, go to DECODE.
  - Otherwise hold request and address stable.
- DECODE
  - Read ra/rb/rd into operand latches.
  - HALT goes to HALT; every other opcode goes to EXECUTE.
- EXECUTE
  - ALU ops compute the result and flags, then go to WB.
  - LD/ST compute the address, then go to MEM.
  - Branch/JMP: load pc if taken, then go to FETCH.
  - NOP/reserved go to FETCH.
  - LDI goes to WB.
- MEM
  - dmem_req=1; dmem_we, dmem_addr and dmem_wdata held stable until dmem_ready=1.
  - LD then goes to WB; ST goes to FETCH.
- WB
  - Write rd and pulse dbg_wb_valid, then go to FETCH.
- HALT
  - halted=1, no requests.
  - Left only by reset.

**Handshake rules:**
- A ready input is ignored unless the matching req is high in that cycle.
- ready may be high in the same cycle req rises (zero-wait memory).
- req never drops before ready.

## Timing
- **Reset (async, immediate):**
  - state=FETCH, pc=0, all registers 0, flags 0.
  - imem_req=0 during reset; it rises the first cycle after release.
  - dmem_req=0, halted=0, dbg_wb_valid=0.
- **Reset mid-access:** the request drops immediately and the transaction is abandoned.
- **Cycle counts with zero-wait memory:**
  - ALU/LDI: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - Branch/JMP/NOP: 3 cycles.
  - Each memory wait cycle adds 1.
- **Branch target base:** the pc of the next instruction (pc+1 at fetch).
- **Register write timing:** writes happen at the end of WB; the next instruction's DECODE sees the new value.
- **Flag timing:** flags written in EXECUTE are visible to a branch in the following instruction.

## Structure
- **Package `mcpu_pkg`:**
  - opcode enum
  - state enum (FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5)
  - field bit positions
  - instruction width 16
- **Sub-module `mcpu_regfile`:**
  - Ports: DATA_W×8, three async read ports, one sync write port, async active-low clear.
- **Top:** the ALU and FSM are inline in the top.

## Test plan
- **ALU and flags:**
  - Stimulus: LDI r1,5; LDI r2,5; SUB r3,r1,r2.
  - Required: dbg_wb r3=0; zero_flag=1, carrier_flag=1, negative_flag=0; SUB retires 4 cycles after its fetch.
- **Conditional branch:**
  - Stimulus: flags from the previous case, then BZ +2 at pc=3.
  - Required: next imem_addr=6. Repeat with Z=0: next imem_addr=4.
- **Memory wait states:**
  - Stimulus: ST r1→mem[r0+3], then LD r4,mem[3], with dmem_ready delayed 3 cycles.
  - Required: dmem_addr=3 and dmem_wdata=5 held stable throughout; r4=5; LD takes 8 cycles.
- **Width and wrap:**
  - Stimulus: DATA_W=8, LDI r1,255; ADDI r1,r1,1.
  - Required: r1=0, carrier_flag=1, zero_flag=1.
  - Stimulus: JMP from pc=255 with PC_W=8.
  - Required: wraps correctly.
- **HALT and reset:**
  - Stimulus: HALT.
  - Required: halted=1; no further imem_req for 20 cycles.
  - Stimulus: assert reset_CPU=0 during a stalled dmem access.
  - Required: dmem_req drops immediately; after release pc=0 and the core fetches from address 0.
